confreg_sram: RTL and testbench

Memory-mapped configuration/peripheral responder on the CPU data SRAM-style port. It takes the same en/wen/addr/wdata/rdata transactions the CPU issues to data RAM and answers with the same 1-cycle registered read latency, so it can share or replace a data RAM port. It holds an LED register, a synchronized switch input, a free-running timer with compare and a sticky match flag driving an interrupt line, and two scratch registers.

---
 rtl/confreg_sram.sv | 141 ++++++++++++++
 tb/tb_confreg_sram.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/confreg_sram.sv
// confreg_sram: configuration/peripheral responder on an SRAM-style data port.
// Holds LED, synchronized switches, a free-running timer with compare and a
// sticky match flag (irq), and two scratch registers. Reads return the
// pre-edge register value with one cycle of registered latency.
module confreg_sram #(
    parameter int          LED_W      = 16,
    parameter int          SW_W       = 16,
    parameter logic [31:0] TIMER_INIT = 32'h0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              sram_en,
    input  logic [3:0]        sram_wen,
    input  logic [31:0]       sram_addr,
    input  logic [31:0]       sram_wdata,
    output logic [31:0]       sram_rdata,
    input  logic [SW_W-1:0]   switch,
    output logic [LED_W-1:0]  led,
    output logic              irq
);

    localparam logic [13:0] A_LED     = 14'd0;
    localparam logic [13:0] A_SWITCH  = 14'd1;
    localparam logic [13:0] A_TIMER   = 14'd2;
    localparam logic [13:0] A_CMP     = 14'd3;
    localparam logic [13:0] A_STATUS  = 14'd4;
    localparam logic [13:0] A_SCRATCH0 = 14'd5;
    localparam logic [13:0] A_SCRATCH1 = 14'd6;

    logic [LED_W-1:0] led_reg;
    logic [SW_W-1:0]  sw_sync1;
    logic [SW_W-1:0]  sw_sync2;
    logic [31:0]      timer;
    logic [31:0]      timer_cmp;
    logic             match;
    logic [31:0]      scratch0;
    logic [31:0]      scratch1;
    logic [31:0]      rdata_reg;

    logic [13:0] word;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] led_ext;
    logic [31:0] sw_ext;
    logic [31:0] led_wr;
    logic [31:0] rd_val;
    logic        match_hit;
    logic        match_clr;

    // Only the word offset within the 64 KB window selects a register.
    logic unused_addr;
    logic [31:0] unused_led_wr;
    assign unused_addr   = ^{sram_addr[31:16], sram_addr[1:0]};
    assign unused_led_wr = led_wr;

    assign word  = sram_addr[15:2];
    assign wr_en = sram_en & (|sram_wen);
    assign rd_en = sram_en & ~(|sram_wen);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
        end
        return r;
    endfunction

    // Zero-extend the narrow registers to the 32-bit bus width.
    always_comb begin
        led_ext = '0;
        sw_ext  = '0;
        led_ext[LED_W-1:0] = led_reg;
        sw_ext[SW_W-1:0]   = sw_sync2;
        led_wr  = merge_bytes(led_ext, sram_wdata, sram_wen);
    end

    // Read mux over the pre-edge register values; unmapped offsets read 0.
    always_comb begin
        rd_val = '0;
        case (word)
            A_LED:      rd_val = led_ext;
            A_SWITCH:   rd_val = sw_ext;
            A_TIMER:    rd_val = timer;
            A_CMP:      rd_val = timer_cmp;
            A_STATUS:   rd_val = {31'd0, match};
            A_SCRATCH0: rd_val = scratch0;
            A_SCRATCH1: rd_val = scratch1;
            default:    rd_val = '0;
        endcase
    end

    // A compare hit on the current timer value wins over a W1C clear.
    always_comb begin
        match_hit = (timer == timer_cmp);
        match_clr = wr_en && (word == A_STATUS) && sram_wen[0] && sram_wdata[0];
    end

    // Register file, timer, switch synchronizer and registered read data.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            led_reg   <= '0;
            sw_sync1  <= '0;
            sw_sync2  <= '0;
            timer     <= TIMER_INIT;
            timer_cmp <= 32'hFFFF_FFFF;
            match     <= 1'b0;
            scratch0  <= '0;
            scratch1  <= '0;
            rdata_reg <= '0;
        end else begin
            sw_sync1 <= switch;
            sw_sync2 <= sw_sync1;
            match    <= match_hit | (match & ~match_clr);

            if (wr_en && word == A_TIMER)
                timer <= merge_bytes(timer, sram_wdata, sram_wen);
            else
                timer <= timer + 32'd1;

            if (wr_en && word == A_LED)
                led_reg <= led_wr[LED_W-1:0];
            if (wr_en && word == A_CMP)
                timer_cmp <= merge_bytes(timer_cmp, sram_wdata, sram_wen);
            if (wr_en && word == A_SCRATCH0)
                scratch0 <= merge_bytes(scratch0, sram_wdata, sram_wen);
            if (wr_en && word == A_SCRATCH1)
                scratch1 <= merge_bytes(scratch1, sram_wdata, sram_wen);

            if (rd_en)
                rdata_reg <= rd_val;
        end
    end

    assign sram_rdata = rdata_reg;
    assign led        = led_reg;
    assign irq        = match;

endmodule

// File: tb/tb_confreg_sram.sv
// Self-checking bench for confreg_sram: reads push their expected data onto a
// scoreboard queue and are compared one cycle later when rdata is sampled.
module tb_confreg_sram;

    localparam logic [31:0] TINIT = 32'h0000_0100;

    logic        clk;
    logic        resetn;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [15:0] switch;
    logic [15:0] led;
    logic        irq;

    confreg_sram #(
        .LED_W(16),
        .SW_W(16),
        .TIMER_INIT(TINIT)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .sram_en(sram_en),
        .sram_wen(sram_wen),
        .sram_addr(sram_addr),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata),
        .switch(switch),
        .led(led),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;
    int cyc;
    bit rd_now;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] tw_val;
    int          tw_cyc;
    logic [31:0] tmp;

    // Compare one observed value against its expectation.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Timer value seen by a read/compare at edge e, given the last load.
    function automatic logic [31:0] tmr_at(input int e);
        return tw_val + 32'(e - tw_cyc) - 32'd1;
    endfunction

    task automatic tick();
        string t;
        logic [31:0] e;
        @(posedge clk);
        cyc++;
        #1;
        if (rd_now) begin
            rd_now = 1'b0;
            if (exp_q.size() == 0) begin
                check_val("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check_val(t, sram_rdata, e);
            end
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        sram_en = 1'b1; sram_wen = be; sram_addr = a; sram_wdata = d;
        tick();
        sram_en = 1'b0; sram_wen = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        sram_en = 1'b1; sram_wen = 4'h0; sram_addr = a;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        rd_now = 1'b1;
        tick();
        sram_en = 1'b0;
    endtask

    task automatic idle();
        sram_en = 1'b0;
        tick();
    endtask

    task automatic write_timer(input logic [31:0] v);
        wr(32'h8, v, 4'hF);
        tw_val = v;
        tw_cyc = cyc;
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; rd_now = 1'b0;
        resetn = 1'b0; sram_en = 1'b0; sram_wen = 4'h0;
        sram_addr = '0; sram_wdata = '0; switch = '0;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("rst_rdata", sram_rdata, 32'h0);
            check_val("rst_led", {16'h0, led}, 32'h0);
            check_val("rst_irq", {31'h0, irq}, 32'h0);
        end
        tw_val = TINIT; tw_cyc = cyc;
        resetn = 1'b1;
        rd(32'h8, tmr_at(cyc + 1), "timer_init");
        rd(32'hC, 32'hFFFF_FFFF, "cmp_rst");
        rd(32'h10, 32'h0, "status_rst");
        rd(32'h4, 32'h0, "switch_rst");
        rd(32'h14, 32'h0, "scratch0_rst");

        // Byte enables.
        wr(32'h14, 32'hAABB_CCDD, 4'hF);
        wr(32'h14, 32'h1122_3344, 4'b0101);
        rd(32'h14, 32'hAA22_CC44, "scratch0_be");
        wr(32'h1B, 32'hDEAD_BEEF, 4'hF);
        wr(32'h18, 32'h0, 4'b1000);
        rd(32'h18, 32'h00AD_BEEF, "scratch1_be");

        // LED width clipping.
        wr(32'h0, 32'hFFFF_FFFF, 4'hF);
        rd(32'h0, 32'h0000_FFFF, "led_clip");
        check_val("led_out_ff", {16'h0, led}, 32'h0000_FFFF);
        wr(32'h0, 32'h3, 4'hF);
        check_val("led_out_3", {16'h0, led}, 32'h3);

        // Timer/compare: match when pre-edge timer reaches 0x14.
        write_timer(32'h10);
        wr(32'hC, 32'h14, 4'hF);
        check_val("irq_pre1", {31'h0, irq}, 32'h0);
        for (int k = 2; k <= 4; k++) begin
            idle();
            check_val("irq_pre", {31'h0, irq}, 32'h0);
        end
        idle();
        check_val("irq_rise", {31'h0, irq}, 32'h1);
        rd(32'h10, 32'h1, "status_match");
        wr(32'h10, 32'h1, 4'h1);
        check_val("irq_w1c", {31'h0, irq}, 32'h0);
        rd(32'h8, tmr_at(cyc + 1), "timer_run0");
        rd(32'h8, tmr_at(cyc + 1), "timer_run1");

        // Match set wins over a coincident W1C.
        wr(32'hC, tmr_at(cyc + 2), 4'hF);
        wr(32'h10, 32'h1, 4'h1);
        check_val("set_over_clr", {31'h0, irq}, 32'h1);
        wr(32'h10, 32'h1, 4'h1);
        check_val("clr_after", {31'h0, irq}, 32'h0);

        // Wrap and write priority.
        write_timer(32'hFFFF_FFFE);
        rd(32'h8, 32'hFFFF_FFFE, "wrap_fe");
        rd(32'h8, 32'hFFFF_FFFF, "wrap_ff");
        rd(32'h8, 32'h0000_0000, "wrap_00");
        tmp = tmr_at(cyc + 1);
        wr(32'h8, 32'h0000_0055, 4'b0001);
        tw_val = {tmp[31:8], 8'h55}; tw_cyc = cyc;
        rd(32'h8, {tmp[31:8], 8'h55}, "timer_partial");
        idle();
        write_timer(32'h200);
        rd(32'h8, 32'h200, "timer_prio");

        // Switch synchronizer.
        switch = 16'h5A5A;
        idle();
        idle();
        rd(32'h4, 32'h0000_5A5A, "switch_5a");
        switch = 16'h1234;
        rd(32'h4, 32'h0000_5A5A, "switch_lat1");
        rd(32'h4, 32'h0000_5A5A, "switch_lat2");
        rd(32'h4, 32'h0000_1234, "switch_new");

        // Unmapped and read-only offsets.
        rd(32'h40, 32'h0, "unmapped_rd");
        wr(32'h4, 32'hFFFF_FFFF, 4'hF);
        wr(32'h40, 32'hFFFF_FFFF, 4'hF);
        rd(32'h4, 32'h0000_1234, "switch_ro");
        rd(32'h40, 32'h0, "unmapped_wr");

        // rdata holds through idle cycles and writes.
        rd(32'h0, 32'h3, "led_rd");
        for (int i = 0; i < 10; i++) begin
            sram_en = 1'b0; sram_wen = 4'hF; sram_addr = 32'h0; sram_wdata = 32'hFFFF_FFFF;
            tick();
            check_val("hold_idle", sram_rdata, 32'h3);
        end
        sram_wen = 4'h0;
        wr(32'h14, 32'h99, 4'hF);
        check_val("hold_wr", sram_rdata, 32'h3);
        rd(32'h0, 32'h3, "led_en0");
        check_val("led_out_en0", {16'h0, led}, 32'h3);

        // Reset mid-stream discards the read issued in that cycle.
        sram_en = 1'b1; sram_wen = 4'h0; sram_addr = 32'h14;
        exp_q.push_back(32'h0);
        tag_q.push_back("rst_read");
        rd_now = 1'b1;
        resetn = 1'b0;
        tick();
        sram_en = 1'b0;
        check_val("rst2_led", {16'h0, led}, 32'h0);
        check_val("rst2_irq", {31'h0, irq}, 32'h0);
        tick();
        tw_val = TINIT; tw_cyc = cyc;
        resetn = 1'b1;
        rd(32'h8, TINIT, "rst2_timer");
        rd(32'h14, 32'h0, "rst2_scratch0");
        rd(32'hC, 32'hFFFF_FFFF, "rst2_cmp");
        rd(32'h0, 32'h0, "rst2_led_rd");

        if (exp_q.size() != 0) check_val("scoreboard_left", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
